glitch_sweep_ctrl: RTL and testbench
====================================

// Module: glitch_sweep_ctrl
// PURPOSE
// - Campaign sequencer directly upstream of the glitchy-clock generator: drives its phase, glitch_pos,
//   glitch_en and start_enc inputs and reads its dll_locked output.
// - Sweeps a 2-D grid of glitch settings: the outer loop steps phase, the inner loop steps glitch_pos.
// - Runs one encryption per grid point and reports the end of each run and the end of the whole sweep.
// PARAMETERS
// PHASE_W      8      width of phase and the phase_* bounds
// POS_W        16     width of glitch_pos and the pos_* bounds
// SETTLE_CYC   64     wait in cycles after a phase/pos update before the DLL-lock check
// TIMEOUT_CYC  65535  longest wait for enc_busy to rise and then fall
// CNT_W        24     width of run_cnt
// PORTS
// clk          in   1        system clock; all logic is on its rising edge
// rst_in       in   1        asynchronous reset, active-high
// start        in   1        one-cycle pulse that starts a sweep; ignored while busy=1
// abort        in   1        one-cycle pulse that stops the sweep and returns to IDLE
// phase_min    in   PHASE_W  first phase value
// phase_max    in   PHASE_W  last phase value
// phase_step   in   PHASE_W  phase increment
// pos_min      in   POS_W    first glitch position
// pos_max      in   POS_W    last glitch position
// pos_step     in   POS_W    glitch-position increment
// dll_locked   in   1        generator DLL lock; asynchronous, 2-flop synchronised inside
// enc_busy     in   1        crypto core busy flag
// phase        out  PHASE_W  phase to the generator
// glitch_pos   out  POS_W    glitch position to the generator
// glitch_en    out  1        glitch enable to the generator
// start_enc    out  1        one-cycle pulse that starts the encryption
// busy         out  1        high whenever the FSM is not in IDLE
// run_done     out  1        one-cycle pulse at the end of each run
// run_timeout  out  1        valid with run_done: 1 = the run timed out
// sweep_done   out  1        one-cycle pulse after the last grid point
// run_cnt      out  CNT_W    number of completed runs in the current sweep
// BEHAVIOUR
// - Reset: every output is 0, the FSM is in IDLE and the counters are cleared. Reset mid-sweep drops
//   all state immediately; nothing is pulsed.
// - Bounds and steps are sampled into internal registers on an accepted start and held for the whole sweep.
//   A step value of 0 is treated as 1. If min>max, the sweep runs at min only (one point on that axis).
// - FSM states: IDLE -> LOAD -> SETTLE -> FIRE -> WAIT_HI -> WAIT_LO -> REPORT -> NEXT -> (SETTLE | DONE)
// - LOAD: set phase=phase_min and glitch_pos=pos_min; clear run_cnt. Entered the cycle after start.
// - SETTLE: count SETTLE_CYC cycles, then wait for the synchronised dll_locked=1 (no timeout on this wait).
//   The settle counter restarts on every entry to SETTLE.
// - FIRE: glitch_en=1 and start_enc=1 for exactly one cycle. glitch_en stays 1 until REPORT.
// - WAIT_HI: wait for enc_busy=1.
// - WAIT_LO: wait for enc_busy=0.
// - Timeout: one TIMEOUT_CYC counter covers WAIT_HI plus WAIT_LO. If it expires, go to REPORT with
//   run_timeout=1.
// - REPORT: glitch_en=0; run_done=1 for one cycle; run_cnt+1, saturating at all-ones.
// - NEXT: compute glitch_pos+pos_step in POS_W+1 bits.
//   - If the sum <= pos_max: update glitch_pos and go to SETTLE.
//   - Otherwise reset glitch_pos to pos_min and compute phase+phase_step in PHASE_W+1 bits.
//     - If that sum <= phase_max: update phase and go to SETTLE.
//     - Otherwise go to DONE.
//   Carry-out of the wider sum never wraps back to a low value.
// - DONE: sweep_done=1 for one cycle, then IDLE. phase and glitch_pos hold their last values.
// - abort (any state except IDLE): next cycle is IDLE, glitch_en=0, start_enc=0, no pulses.
//   abort and start in the same cycle: abort wins. start while busy=1 is ignored.
// - enc_busy already 1 in FIRE: WAIT_HI exits on the next cycle.
// TESTING
// - phase 0..2 step 1, pos 10..30 step 10, enc model busy for 5 cycles -> 9 run_done, run_cnt=9,
//   grid order phase-major, one sweep_done.
// - pos_min=pos_max=FFF0, pos_step=0x20 -> a single pos per phase, no wrap to a low pos.
// - dll_locked held 0 for 200 cycles -> start_enc only after lock + synchroniser delay; never before SETTLE_CYC.
// - enc_busy never rises, TIMEOUT_CYC=100 -> run_done with run_timeout=1 at 100 cycles after FIRE;
//   the sweep continues.
// - abort during WAIT_LO, then start in the same cycle as abort -> IDLE, glitch_en=0, no sweep_done.
//   A later start restarts at min.
// - rst_in pulsed during SETTLE -> all outputs 0 asynchronously; a fresh start runs normally.

Source files
------------

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl
// Campaign sequencer that sits in front of the glitchy-clock generator. It
// walks a 2-D grid of glitch settings (phase in the outer loop, glitch_pos in
// the inner loop) and runs one encryption per grid point.
//
// Ports
//   clk, rst_in                  clock (rising edge), async active-high reset
//   start, abort                 one-cycle control pulses (abort wins)
//   phase_min/max/step           outer-axis bounds, sampled on accepted start
//   pos_min/max/step             inner-axis bounds, sampled on accepted start
//   dll_locked                   generator lock, asynchronous (2-flop sync)
//   enc_busy                     crypto core busy flag
//   phase, glitch_pos            current grid point to the generator
//   glitch_en, start_enc         glitch enable and encryption start pulse
//   busy                         FSM not in IDLE
//   run_done, run_timeout        end-of-run pulse and its timeout qualifier
//   sweep_done                   end-of-sweep pulse
//   run_cnt                      completed runs in the current sweep
module glitch_sweep_ctrl #(
    parameter int PHASE_W     = 8,
    parameter int POS_W       = 16,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 65535,
    parameter int CNT_W       = 24
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] phase_min,
    input  logic [PHASE_W-1:0] phase_max,
    input  logic [PHASE_W-1:0] phase_step,
    input  logic [POS_W-1:0]   pos_min,
    input  logic [POS_W-1:0]   pos_max,
    input  logic [POS_W-1:0]   pos_step,
    input  logic               dll_locked,
    input  logic               enc_busy,
    output logic [PHASE_W-1:0] phase,
    output logic [POS_W-1:0]   glitch_pos,
    output logic               glitch_en,
    output logic               start_enc,
    output logic               busy,
    output logic               run_done,
    output logic               run_timeout,
    output logic               sweep_done,
    output logic [CNT_W-1:0]   run_cnt
);

    localparam int SC_W = $clog2(SETTLE_CYC + 2);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_FIRE, S_WAIT_HI,
        S_WAIT_LO, S_REPORT, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PHASE_W-1:0] phase_min_r, phase_max_r, phase_step_r;
    logic [POS_W-1:0]   pos_min_r, pos_max_r, pos_step_r;
    logic [1:0]         dll_sync;
    logic [SC_W-1:0]    scnt;
    logic [TO_W-1:0]    tcnt;
    logic               to_flag;
    logic               to_hit;
    logic               settled;
    logic               accept;
    logic               pos_fits;
    logic               phase_fits;
    logic [POS_W:0]     pos_sum;
    logic [PHASE_W:0]   phase_sum;

    // One extra bit on the sums so a step past the top of the range compares
    // as "beyond max" instead of wrapping to a small value.
    assign pos_sum    = {1'b0, glitch_pos} + {1'b0, pos_step_r};
    assign phase_sum  = {1'b0, phase} + {1'b0, phase_step_r};
    assign pos_fits   = (pos_sum <= {1'b0, pos_max_r});
    assign phase_fits = (phase_sum <= {1'b0, phase_max_r});

    assign accept  = (state == S_IDLE) && start && !abort;
    assign settled = (scnt >= SC_W'(SETTLE_CYC));
    // tcnt is 1 in the first wait cycle, so reaching TIMEOUT_CYC-1 here puts
    // REPORT exactly TIMEOUT_CYC cycles after FIRE.
    assign to_hit  = (tcnt >= TO_W'(TIMEOUT_CYC - 1));

    assign busy        = (state != S_IDLE);
    assign start_enc   = (state == S_FIRE);
    assign glitch_en   = (state == S_FIRE) || (state == S_WAIT_HI) || (state == S_WAIT_LO);
    assign run_done    = (state == S_REPORT);
    assign run_timeout = (state == S_REPORT) && to_flag;
    assign sweep_done  = (state == S_DONE);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) dll_sync <= '0;
        else        dll_sync <= {dll_sync[0], dll_locked};
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_SETTLE;
            S_SETTLE:  if (settled && dll_sync[1]) state_nxt = S_FIRE;
            S_FIRE:    state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (enc_busy) state_nxt = S_WAIT_LO;
                       else if (to_hit) state_nxt = S_REPORT;
            S_WAIT_LO: if (!enc_busy || to_hit) state_nxt = S_REPORT;
            S_REPORT:  state_nxt = S_NEXT;
            S_NEXT:    if (pos_fits || phase_fits) state_nxt = S_SETTLE;
                       else state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            phase_min_r  <= '0;
            phase_max_r  <= '0;
            phase_step_r <= '0;
            pos_min_r    <= '0;
            pos_max_r    <= '0;
            pos_step_r   <= '0;
            phase        <= '0;
            glitch_pos   <= '0;
            run_cnt      <= '0;
            scnt         <= '0;
            tcnt         <= '0;
            to_flag      <= 1'b0;
        end else begin
            if (accept) begin
                phase_min_r  <= phase_min;
                phase_max_r  <= phase_max;
                phase_step_r <= (phase_step == '0) ? PHASE_W'(1) : phase_step;
                pos_min_r    <= pos_min;
                pos_max_r    <= pos_max;
                pos_step_r   <= (pos_step == '0) ? POS_W'(1) : pos_step;
            end

            if (state == S_LOAD) begin
                phase      <= phase_min_r;
                glitch_pos <= pos_min_r;
            end else if (state == S_NEXT && !abort) begin
                // On the final point both registers keep the last grid point.
                if (pos_fits) begin
                    glitch_pos <= pos_sum[POS_W-1:0];
                end else if (phase_fits) begin
                    glitch_pos <= pos_min_r;
                    phase      <= phase_sum[PHASE_W-1:0];
                end
            end

            if (state_nxt == S_SETTLE && state != S_SETTLE)
                scnt <= '0;
            else if (state == S_SETTLE && !settled)
                scnt <= scnt + 1'b1;

            if (state == S_FIRE)
                tcnt <= TO_W'(1);
            else if ((state == S_WAIT_HI || state == S_WAIT_LO) && !to_hit)
                tcnt <= tcnt + 1'b1;

            // Count and qualify the run as REPORT is entered, so both are
            // already valid while run_done is high.
            if (state == S_LOAD) begin
                run_cnt <= '0;
            end else if (state_nxt == S_REPORT && state != S_REPORT) begin
                to_flag <= !(state == S_WAIT_LO && !enc_busy);
                if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
module tb_glitch_sweep_ctrl;
    localparam int PW = 8, QW = 16, SC = 8, TO = 100, CW = 24;

    logic          clk = 0, rst_in = 1, start = 0, abort = 0;
    logic [PW-1:0] phase_min = 0, phase_max = 0, phase_step = 0;
    logic [QW-1:0] pos_min = 0, pos_max = 0, pos_step = 0;
    logic          dll_locked = 1, enc_busy = 0;
    logic [PW-1:0] phase;
    logic [QW-1:0] glitch_pos;
    logic          glitch_en, start_enc, busy, run_done, run_timeout, sweep_done;
    logic [CW-1:0] run_cnt;

    glitch_sweep_ctrl #(.PHASE_W(PW), .POS_W(QW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .abort(abort),
        .phase_min(phase_min), .phase_max(phase_max), .phase_step(phase_step),
        .pos_min(pos_min), .pos_max(pos_max), .pos_step(pos_step),
        .dll_locked(dll_locked), .enc_busy(enc_busy),
        .phase(phase), .glitch_pos(glitch_pos), .glitch_en(glitch_en), .start_enc(start_enc),
        .busy(busy), .run_done(run_done), .run_timeout(run_timeout), .sweep_done(sweep_done),
        .run_cnt(run_cnt));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {int ph; int pos; bit to; int cnt;} exp_t;
    exp_t q[$];
    exp_t e;

    int total = 0, bad = 0;
    int sweep_pend = 0, sweep_npts = 0, last_ph = 0;
    int last_ref = 0, last_fire = 0, dll_rise = 0;
    int rd_cnt = 0, sd_cnt = 0;
    bit dll_chk = 0, enc_en = 1;
    int enc_d, enc_l;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_glitch_en"}, glitch_en, 0);
        chk({tag, "_start_enc"}, start_enc, 0);
        chk({tag, "_pulses"}, {run_done, run_timeout, sweep_done}, 0);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_glitch_pos"}, glitch_pos, 0);
        chk({tag, "_run_cnt"}, run_cnt, 0);
    endtask

    // Reference model: the grid as nested loops over plain integers.
    task automatic push_sweep(input int pmin, input int pmax, input int pst,
                              input int qmin, input int qmax, input int qst, input bit to);
        int ps, qs, ph, pos, n;
        ps = (pst == 0) ? 1 : pst;
        qs = (qst == 0) ? 1 : qst;
        ph = pmin;
        n  = 0;
        forever begin
            pos = qmin;
            forever begin
                n++;
                q.push_back('{ph: ph, pos: pos, to: to, cnt: n});
                if (pos + qs <= qmax) pos += qs;
                else break;
            end
            last_ph = ph;
            if (ph + ps <= pmax) ph += ps;
            else break;
        end
        sweep_npts = n;
        sweep_pend++;
    endtask

    task automatic do_start(input int pmin, input int pmax, input int pst,
                            input int qmin, input int qmax, input int qst);
        @(posedge clk); #1;
        phase_min = PW'(pmin); phase_max = PW'(pmax); phase_step = PW'(pst);
        pos_min = QW'(qmin); pos_max = QW'(qmax); pos_step = QW'(qst);
        start = 1;
        last_ref = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_sweep();
        int n = 0;
        while ((q.size() != 0 || sweep_pend != 0) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            total++; bad++;
            $display("FAIL sweep_wait: got no sweep_done after %0d cycles, required completion", n);
            q.delete();
            sweep_pend = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("hold_phase", phase, last_ph);
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_sweep(input int pmin, input int pmax, input int pst,
                            input int qmin, input int qmax, input int qst, input bit to);
        int rd0;
        rd0 = rd_cnt;
        push_sweep(pmin, pmax, pst, qmin, qmax, qst, to);
        do_start(pmin, pmax, pst, qmin, qmax, qst);
        wait_sweep();
        chk("run_done_count", rd_cnt - rd0, sweep_npts);
    endtask

    // Encryption core model: busy for a few cycles after each start_enc.
    initial forever begin
        @(negedge clk);
        if (start_enc && enc_en && !rst_in) begin
            enc_d = $urandom_range(0, 2);
            enc_l = $urandom_range(3, 6);
            repeat (enc_d) @(negedge clk);
            enc_busy = 1;
            repeat (enc_l) @(negedge clk);
            enc_busy = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports.
    initial forever begin
        @(negedge clk);
        if (!rst_in) begin
            if (start_enc) begin
                chk("fire_glitch_en", glitch_en, 1);
                if (dll_chk) begin
                    chk_rng("fire_after_lock", cyc, dll_rise + 2, dll_rise + 4);
                    dll_chk = 0;
                end else begin
                    chk_rng("settle_gap", cyc - last_ref, SC + 2, SC + 4);
                end
                last_fire = cyc;
            end
            if (sweep_done) begin
                sd_cnt++;
                if (sweep_pend == 0) begin
                    total++; bad++;
                    $display("FAIL sweep_done: got unexpected pulse, required none (cycle %0d)", cyc);
                end else begin
                    chk("sweep_run_cnt", run_cnt, sweep_npts);
                    chk("sweep_left_points", q.size(), 0);
                    sweep_pend--;
                end
            end
            if (run_done) begin
                rd_cnt++;
                last_ref = cyc;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL run_done: got unexpected pulse, required none (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("run_phase", phase, e.ph);
                    chk("run_pos", glitch_pos, e.pos);
                    chk("run_timeout", run_timeout, e.to);
                    chk("report_glitch_en", glitch_en, 0);
                    chk("report_busy", busy, 1);
                    if (e.to) chk("timeout_latency", cyc - last_fire, TO);
                    @(negedge clk);
                    chk("run_cnt", run_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int a, b, c, d, f, g, sd0;
        #3;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_in = 0;

        // main grid: 3 phases x 3 positions, phase-major
        do_sweep(0, 2, 1, 10, 30, 10, 0);

        // top-of-range position, oversized step: one position per phase
        do_sweep(0, 2, 1, 16'hFFF0, 16'hFFF0, 16'h20, 0);

        // DLL held unlocked for 200 cycles
        dll_locked = 0;
        dll_rise = 1 << 30;
        dll_chk = 1;
        push_sweep(1, 1, 1, 5, 5, 1, 0);
        do_start(1, 1, 1, 5, 5, 1);
        repeat (200) @(posedge clk);
        #1;
        dll_rise = cyc;
        dll_locked = 1;
        wait_sweep();

        // enc_busy never rises: every run times out, sweep still advances
        enc_en = 0;
        do_sweep(5, 5, 0, 100, 101, 1, 1);
        enc_en = 1;

        // abort during WAIT_LO with start in the same cycle
        push_sweep(3, 4, 1, 0, 5, 5, 0);
        do_start(3, 4, 1, 0, 5, 5);
        begin
            int n = 0;
            while (enc_busy !== 1'b1 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            chk("abort_busy_seen", enc_busy, 1);
        end
        abort = 1; start = 1;
        q.delete(); sweep_pend = 0;
        sd0 = sd_cnt;
        @(posedge clk); #1;
        abort = 0; start = 0;
        chk("abort_idle", busy, 0);
        chk("abort_glitch_en", glitch_en, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_sweep_done", sd_cnt, sd0);
        chk("abort_stays_idle", busy, 0);
        do_sweep(3, 4, 1, 0, 5, 5, 0);

        // asynchronous reset during SETTLE
        do_start(7, 8, 1, 3, 3, 1);
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst_in = 1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk); @(negedge clk);
        rst_in = 0;
        do_sweep(7, 8, 1, 3, 3, 1, 0);

        // randomized grids, including step 0, min>max and ranges near the top
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) b = (a > 0) ? a - 1 : 0;
            else b = (a + $urandom_range(0, 3) > 255) ? 255 : a + $urandom_range(0, 3);
            c = $urandom_range(0, 2);
            d = ($urandom_range(0, 2) == 0) ? 65535 - $urandom_range(0, 20) : $urandom_range(0, 65535);
            if ($urandom_range(0, 3) == 0) f = (d > 0) ? d - 1 : 0;
            else f = (d + 24 > 65535) ? 65535 : d + $urandom_range(0, 24);
            g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 20);
            do_sweep(a, b, c, d, f, g, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
